// File: rtl/steer_en_sm_if.sv
// Load-cell / battery readings in, rider status out.
// master = A2D/control side, slave = steer_en_sm.
interface steer_en_sm_if;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] batt;
  logic        en_steer;
  logic        rider_off;
  logic        batt_low;

  modport master (
    output lft_ld, rght_ld, batt,
    input  en_steer, rider_off, batt_low
  );

  modport slave (
    input  lft_ld, rght_ld, batt,
    output en_steer, rider_off, batt_low
  );
endinterface

// File: rtl/steer_en_sm.sv
// Rider-detect / steering-enable FSM; no backpressure, inputs sampled every cycle.
// Load change reaches state and outputs 2 clocks later; batt_low lags batt by 1 clock.
module steer_en_sm #(
  parameter logic [11:0] MIN_RIDER_WT = 12'h200,
  parameter logic [11:0] WT_HYST      = 12'h040,
  parameter logic [11:0] BATT_THRES   = 12'h980,
  parameter int unsigned TMR_BITS     = 26
) (
  input  logic          clk,
  input  logic          rst,
  steer_en_sm_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STEER = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [12:0]           sum_q, sum_d;
  logic [11:0]           diff_q, diff_d;
  logic                  batt_low_q, batt_low_d;
  logic [TMR_BITS-1:0]   tmr_q, tmr_d;
  logic                  clr_tmr;

  always_comb begin
    sum_d      = {1'b0, bus.lft_ld} + {1'b0, bus.rght_ld};
    diff_d     = (bus.lft_ld >= bus.rght_ld) ? (bus.lft_ld - bus.rght_ld)
                                             : (bus.rght_ld - bus.lft_ld);
    batt_low_d = (bus.batt < BATT_THRES);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q      <= '0;
      diff_q     <= '0;
      batt_low_q <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      diff_q     <= diff_d;
      batt_low_q <= batt_low_d;
    end
  end

  // All threshold math widened to 17 bits so 16*diff and 15*sum never truncate.
  logic [16:0] sum_w, diff_w, min_w, gone_w;
  logic        present, gone, unbal_wait, unbal_run, tmr_full;

  always_comb begin
    sum_w      = {4'b0, sum_q};
    diff_w     = {5'b0, diff_q};
    min_w      = {5'b0, MIN_RIDER_WT};
    gone_w     = {5'b0, MIN_RIDER_WT - WT_HYST};
    present    = (sum_w > min_w);
    gone       = (sum_w <= gone_w);
    unbal_wait = ((diff_w << 2) > sum_w);
    unbal_run  = ((diff_w << 4) > (sum_w * 17'd15));
    tmr_full   = &tmr_q;
  end

  always_comb begin
    state_d = state_q;
    clr_tmr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (present) begin
          state_d = ST_WAIT;
          clr_tmr = 1'b1;
        end
      end
      ST_WAIT: begin
        if (gone) begin
          state_d = ST_IDLE;
        end else if (unbal_wait) begin
          clr_tmr = 1'b1;
        end else if (tmr_full) begin
          state_d = ST_STEER;
        end
      end
      ST_STEER: begin
        if (gone) begin
          state_d = ST_IDLE;
        end else if (unbal_run) begin
          state_d = ST_WAIT;
          clr_tmr = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tmr_d = tmr_q;
    if (clr_tmr) begin
      tmr_d = '0;
    end else if (state_q == ST_WAIT) begin
      tmr_d = tmr_q + TMR_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  assign bus.en_steer  = (state_q == ST_STEER);
  assign bus.rider_off = (state_q == ST_IDLE);
  assign bus.batt_low  = batt_low_q;

endmodule

// File: tb/tb_steer_en_sm.sv
// Directed bench for steer_en_sm with a 4-bit settle timer (16-cycle settle).
module tb_steer_en_sm;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  steer_en_sm_if bus ();

  steer_en_sm #(
    .MIN_RIDER_WT(12'h200),
    .WT_HYST     (12'h040),
    .BATT_THRES  (12'h980),
    .TMR_BITS    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [11:0] l, input logic [11:0] r);
    bus.lft_ld  = l;
    bus.rght_ld = r;
  endtask

  task automatic wait_en(input string tag, input int max);
    int k;
    k = 0;
    while (bus.en_steer !== 1'b1 && k < max) begin
      tick(1);
      k++;
    end
    chk(tag, {31'b0, bus.en_steer}, 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    drive(12'h300, 12'h300);
    bus.batt = 12'hA00;
    tick(3);
    chk("rst_en",    {31'b0, bus.en_steer},  32'd0);
    chk("rst_roff",  {31'b0, bus.rider_off}, 32'd1);
    chk("rst_blow",  {31'b0, bus.batt_low},  32'd0);
    chk("rst_tmr",   {28'b0, dut.tmr_q},     32'd0);
    chk("rst_sum",   {19'b0, dut.sum_q},     32'd0);

    // Release: stage 1 fills on the first edge, state moves on the second.
    rst = 1'b0;
    tick(1);
    chk("rel1_roff", {31'b0, bus.rider_off}, 32'd1);
    tick(1);
    chk("rel2_roff", {31'b0, bus.rider_off}, 32'd0);
    chk("rel2_en",   {31'b0, bus.en_steer},  32'd0);
    chk("rel2_tmr",  {28'b0, dut.tmr_q},     32'd0);
    tick(7);
    chk("wait7_tmr", {28'b0, dut.tmr_q},     32'd7);

    // Reset in WAIT.
    rst = 1'b1;
    tick(1);
    chk("mrst_roff", {31'b0, bus.rider_off}, 32'd1);
    chk("mrst_en",   {31'b0, bus.en_steer},  32'd0);
    chk("mrst_tmr",  {28'b0, dut.tmr_q},     32'd0);
    drive(12'h180, 12'h180);
    tick(1);
    rst = 1'b0;
    tick(2);
    chk("w_entry_roff", {31'b0, bus.rider_off}, 32'd1 - 32'd1);
    chk("w_entry_tmr",  {28'b0, dut.tmr_q},     32'd0);
    tick(15);
    chk("settle15_en",  {31'b0, bus.en_steer},  32'd0);
    tick(1);
    chk("settle16_en",  {31'b0, bus.en_steer},  32'd1);
    chk("settle16_roff",{31'b0, bus.rider_off}, 32'd0);

    // Rider steps off (sum 1C0 == gone threshold).
    drive(12'h0E0, 12'h0E0);
    tick(2);
    chk("off_roff",  {31'b0, bus.rider_off}, 32'd1);

    // Unbalance mid-WAIT clears the timer.
    drive(12'h180, 12'h180);
    tick(2);
    chk("w2_roff",   {31'b0, bus.rider_off}, 32'd0);
    tick(9);
    chk("w2_tmr9",   {28'b0, dut.tmr_q},     32'd9);
    drive(12'h280, 12'h080);
    tick(2);
    chk("unb_tmr",   {28'b0, dut.tmr_q},     32'd0);
    chk("unb_en",    {31'b0, bus.en_steer},  32'd0);
    chk("unb_roff",  {31'b0, bus.rider_off}, 32'd0);
    drive(12'h180, 12'h180);
    tick(1);
    chk("unb_last_clr", {28'b0, dut.tmr_q},  32'd0);
    tick(15);
    chk("resettle15_en", {31'b0, bus.en_steer}, 32'd0);
    tick(1);
    chk("resettle16_en", {31'b0, bus.en_steer}, 32'd1);

    // 16*2E0=2E00 is not above 15*320=2EE0: stays enabled.
    drive(12'h300, 12'h020);
    tick(3);
    chk("run_bal_en", {31'b0, bus.en_steer}, 32'd1);
    // 16*300=3000 is above 15*300=2D00: back to WAIT.
    drive(12'h300, 12'h000);
    tick(2);
    chk("run_unb_en",   {31'b0, bus.en_steer},  32'd0);
    chk("run_unb_roff", {31'b0, bus.rider_off}, 32'd0);

    // Hysteresis band from STEER_EN, then drop out, then sit at 200.
    drive(12'h180, 12'h180);
    wait_en("resteer_en", 40);
    drive(12'h0F0, 12'h0F0);
    tick(4);
    chk("band_steer_en", {31'b0, bus.en_steer}, 32'd1);
    drive(12'h0E0, 12'h0E0);
    tick(2);
    chk("gone_roff",  {31'b0, bus.rider_off}, 32'd1);
    chk("gone_en",    {31'b0, bus.en_steer},  32'd0);
    drive(12'h100, 12'h100);
    tick(4);
    chk("at_min_roff", {31'b0, bus.rider_off}, 32'd1);

    // Band holds WAIT; gone beats unbalance from WAIT.
    drive(12'h180, 12'h180);
    tick(2);
    chk("w3_roff",   {31'b0, bus.rider_off}, 32'd0);
    drive(12'h0F0, 12'h0F0);
    tick(4);
    chk("band_wait_roff", {31'b0, bus.rider_off}, 32'd0);
    chk("band_wait_en",   {31'b0, bus.en_steer},  32'd0);
    drive(12'h1C0, 12'h000);
    tick(2);
    chk("gone_unb_roff",  {31'b0, bus.rider_off}, 32'd1);

    // Full-scale loads: no wrap.
    drive(12'hFFF, 12'hFFF);
    tick(1);
    chk("max_sum",   {19'b0, dut.sum_q},  32'h1FFE);
    chk("max_diff",  {20'b0, dut.diff_q}, 32'h0);
    wait_en("max_steer_en", 40);

    // Battery threshold; en_steer unaffected.
    bus.batt = 12'h97F;
    tick(1);
    chk("batt_lo",    {31'b0, bus.batt_low}, 32'd1);
    chk("batt_lo_en", {31'b0, bus.en_steer}, 32'd1);
    bus.batt = 12'h980;
    tick(1);
    chk("batt_ok",    {31'b0, bus.batt_low}, 32'd0);
    chk("batt_ok_en", {31'b0, bus.en_steer}, 32'd1);

    // Reset from STEER_EN.
    rst = 1'b1;
    tick(1);
    chk("srst_roff", {31'b0, bus.rider_off}, 32'd1);
    chk("srst_en",   {31'b0, bus.en_steer},  32'd0);
    chk("srst_tmr",  {28'b0, dut.tmr_q},     32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
